// File: rtl/dma_mc_pkg.sv
// Shared types and constants for the multi-channel DMA controller.
package dma_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_RWAIT, S_WR, S_NEXT, S_DONE, S_REL
  } dma_state_t;

  localparam logic [1:0] SingleM2M = 2'd0;
  localparam logic [1:0] BurstM2M  = 2'd1;
  localparam logic [1:0] BurstIO2M = 2'd2;
  localparam logic [1:0] BurstM2IO = 2'd3;

  localparam logic Read     = 1'b1;
  localparam logic Write    = 1'b0;
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  // Channel index width; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_mc_if.sv
// Shared memory/IO bus as seen by the DMA (master) and the bus/memory side (slave).
interface dma_mc_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              breq_;
  logic              bgrt_;
  logic [ADDR_W-1:0] addr;
  logic              rw_;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output breq_, addr, rw_, wdata, input bgrt_, rdata);
  modport slave  (input breq_, addr, rw_, wdata, output bgrt_, rdata);
endinterface

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter: search starts at the channel after the last one served.
module dma_rr_arb import dma_mc_pkg::*; #(
  parameter int NCH = 2,
  localparam int IW = idx_w(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] pend_i,
  input  logic           adv_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NCH; k++) begin
      j = (int'(ptr_q) + k) % NCH;
      if (!found && pend_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    ptr_d = ptr_q;
    if (adv_i && found) ptr_d = (int'(idx_o) == NCH - 1) ? '0 : idx_o + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel DMA controller: per-channel registers, round-robin selection, read-then-write mover.
// DMA_AUTOINIT_EN: channels reload shadow address/count on completion and re-pend while dreq_ is low.
module dma_mc import dma_mc_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int NCH    = 2,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        dreq_,
  input  logic [NCH*ADDR_W-1:0] dsaddr,
  input  logic [NCH*ADDR_W-1:0] ddaddr,
  input  logic [NCH*CNT_W-1:0]  dcount,
  input  logic [NCH*2-1:0]      dmode,
  output logic [NCH-1:0]        eop_,
  output logic                  busy,
  dma_mc_if.master              bus
);

  localparam int IW = idx_w(NCH);

  dma_state_t        state_q, state_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [DATA_W-1:0] data_q;

  logic [NCH-1:0]    armed_v, zc_v, req_v, cur_oh, arb_pend, arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [ADDR_W-1:0] src_v [NCH];
  logic [ADDR_W-1:0] dst_v [NCH];
  logic [CNT_W-1:0]  cnt_v [NCH];
  logic [1:0]        mode_v [NCH];
  logic              step, done, rel;

  assign step = (state_q == S_NEXT);
  assign done = (state_q == S_DONE);
  assign rel  = (state_q == S_REL);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic              armed_q, zc_q, arm;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mode_q;
`ifdef DMA_AUTOINIT_EN
    logic [ADDR_W-1:0] sh_src_q, sh_dst_q;
    logic [CNT_W-1:0]  sh_cnt_q;
`endif

    assign arm       = !armed_q && (dreq_[i] == Enable_);
    assign cur_oh[i] = (cur_q == IW'(i));
    // A single-mode channel only competes while its dreq_ is held low.
    assign req_v[i]  = armed_q && ((mode_q != SingleM2M) || (dreq_[i] == Enable_));
    assign armed_v[i] = armed_q;
    assign zc_v[i]    = zc_q;
    assign src_v[i]   = src_q;
    assign dst_v[i]   = dst_q;
    assign cnt_v[i]   = cnt_q;
    assign mode_v[i]  = mode_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        armed_q <= 1'b0;
        zc_q    <= 1'b0;
      end else begin
        zc_q <= arm && (dcount[i*CNT_W +: CNT_W] == '0);
        if (arm) begin
          armed_q <= (dcount[i*CNT_W +: CNT_W] != '0);
        end else if (done && cur_oh[i]) begin
`ifdef DMA_AUTOINIT_EN
          armed_q <= (dreq_[i] == Enable_);
`else
          armed_q <= 1'b0;
`endif
        end
      end
    end

    always_ff @(posedge clk) begin
      if (arm) begin
        src_q  <= dsaddr[i*ADDR_W +: ADDR_W];
        dst_q  <= ddaddr[i*ADDR_W +: ADDR_W];
        cnt_q  <= dcount[i*CNT_W +: CNT_W];
        mode_q <= dmode[i*2 +: 2];
`ifdef DMA_AUTOINIT_EN
        sh_src_q <= dsaddr[i*ADDR_W +: ADDR_W];
        sh_dst_q <= ddaddr[i*ADDR_W +: ADDR_W];
        sh_cnt_q <= dcount[i*CNT_W +: CNT_W];
`endif
      end else if (step && cur_oh[i]) begin
        src_q <= src_q + ADDR_W'(mode_q != BurstIO2M);
        dst_q <= dst_q + ADDR_W'(mode_q != BurstM2IO);
        cnt_q <= cnt_q - CNT_W'(1);
      end
`ifdef DMA_AUTOINIT_EN
      else if (done && cur_oh[i]) begin
        src_q <= sh_src_q;
        dst_q <= sh_dst_q;
        cnt_q <= sh_cnt_q;
      end
`endif
    end
  end

  // During DONE/REL only the served channel is presented so the pointer moves past it.
  assign arb_pend = (done || rel) ? cur_oh : req_v;

  dma_rr_arb #(.NCH(NCH)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .pend_i (arb_pend),
    .adv_i  (done || rel),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  assign eop_ = ~((done ? cur_oh : '0) | zc_v);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_RWAIT) data_q <= bus.rdata;
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    bus.breq_ = Disable_;
    bus.addr  = '0;
    bus.rw_   = Read;
    bus.wdata = '0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          state_d = S_REQ;
          cur_d   = arb_idx;
        end
      end
      S_REQ: begin
        bus.breq_ = Enable_;
        if (bus.bgrt_ == Enable_) state_d = S_RD;
      end
      S_RD: begin
        bus.breq_ = Enable_;
        bus.addr  = src_v[cur_q];
        state_d   = S_RWAIT;
      end
      S_RWAIT: begin
        bus.breq_ = Enable_;
        state_d   = S_WR;
      end
      S_WR: begin
        bus.breq_ = Enable_;
        bus.addr  = dst_v[cur_q];
        bus.rw_   = Write;
        bus.wdata = data_q;
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        bus.breq_ = Enable_;
        if (cnt_v[cur_q] == CNT_W'(1))     state_d = S_DONE;
        else if (mode_v[cur_q] == SingleM2M) state_d = S_REL;
        else if (bus.bgrt_ == Enable_)     state_d = S_RD;
        else                               state_d = S_REQ;
      end
      S_DONE, S_REL: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_mc.sv
// Scoreboard bench for dma_mc: a bus/memory model checks every write against queued expectations.
module tb_dma_mc;
  import dma_mc_pkg::*;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dreq_;
  logic [19:0] dsaddr, ddaddr;
  logic [15:0] dcount;
  logic [3:0]  dmode;
  logic [1:0]  eop_;
  logic        busy;

  dma_mc_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  dma_mc #(.ADDR_W(10), .DATA_W(8), .NCH(2), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .dreq_  (dreq_),
    .dsaddr (dsaddr),
    .ddaddr (ddaddr),
    .dcount (dcount),
    .dmode  (dmode),
    .eop_   (eop_),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  logic [9:0] prev_addr;
  wr_t        wq [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         eop_cnt [2];
  int         grant_cycles = 0;
  int         breq_cycles = 0;
  int         e0 = 0;
  int         e1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus slave: grant follows request, read data valid the cycle after the address, writes scored.
  initial begin
    wr_t e;
    bus.bgrt_  = 1'b1;
    bus.rdata  = 8'h00;
    prev_addr  = '0;
    eop_cnt[0] = 0;
    eop_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (bus.breq_ == Enable_ && bus.bgrt_ == Enable_) grant_cycles++;
      if (bus.breq_ == Enable_) breq_cycles++;
      for (int i = 0; i < 2; i++) if (eop_[i] == 1'b0) eop_cnt[i]++;
      if (bus.breq_ == Enable_ && bus.rw_ == Write) begin
        chk("wr_pending", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("wr_addr", 32'(bus.addr), 32'(e.addr));
          chk("wr_data", 32'(bus.wdata), 32'(e.data));
        end
        mem[bus.addr] = bus.wdata;
      end
      bus.rdata = mem[prev_addr];
      prev_addr = bus.addr;
      bus.bgrt_ = (bus.breq_ == Enable_) ? Enable_ : Disable_;
    end
  end

  task automatic set_ch(input int ch, input logic [9:0] src, input logic [9:0] dst,
                        input logic [7:0] cnt, input logic [1:0] mode);
    logic [9:0] s, d;
    dsaddr[ch*10 +: 10] = src;
    ddaddr[ch*10 +: 10] = dst;
    dcount[ch*8 +: 8]   = cnt;
    dmode[ch*2 +: 2]    = mode;
    s = src;
    d = dst;
    for (int k = 0; k < int'(cnt); k++) begin
      wq.push_back('{addr: d, data: mem[s]});
      if (mode != BurstIO2M) s = s + 10'd1;
      if (mode != BurstM2IO) d = d + 10'd1;
    end
  endtask

  task automatic pulse(input logic [1:0] m);
    @(posedge clk); #1;
    dreq_ = ~m;
    @(posedge clk); #1;
    dreq_ = 2'b11;
  endtask

  task automatic wait_eop(input int ch, input int target);
    int n = 0;
    while (eop_cnt[ch] < target && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk($sformatf("eop%0d_count", ch), 32'(eop_cnt[ch]), 32'(target));
    chk("sb_drained", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    dreq_  = 2'b11;
    dsaddr = '0;
    ddaddr = '0;
    dcount = '0;
    dmode  = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    mem[10'h150] = 8'd99;  mem[10'h151] = 8'd90;  mem[10'h152] = 8'd50;
    mem[10'h200] = 8'h0F;  mem[10'h201] = 8'h33;
    mem[10'h010] = 8'h11;  mem[10'h011] = 8'h12;  mem[10'h012] = 8'h13;  mem[10'h013] = 8'h14;
    mem[10'h030] = 8'h31;  mem[10'h031] = 8'h32;  mem[10'h032] = 8'h33;
    mem[10'h080] = 8'hC1;  mem[10'h081] = 8'hC2;
    mem[10'h3FF] = 8'hA5;  mem[10'h000] = 8'h5A;
    mem[10'h040] = 8'h41;  mem[10'h041] = 8'h42;  mem[10'h042] = 8'h43;  mem[10'h043] = 8'h44;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_breq", 32'(bus.breq_), 32'd1);
    chk("rst_rw", 32'(bus.rw_), 32'(Read));
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_eop", 32'(eop_), 32'h3);
    chk("rst_busy", 32'(busy), 32'd0);

    // Burst M2M on ch0 with request timeline and bus-hold length
    set_ch(0, 10'h150, 10'h160, 8'd3, BurstM2M);
    grant_cycles = 0;
    pulse(2'b01);
    @(negedge clk);
    chk("t1_breq_armed", 32'(bus.breq_), 32'd1);
    @(negedge clk);
    chk("t1_breq_req", 32'(bus.breq_), 32'd0);
    chk("t1_busy_req", 32'(busy), 32'd1);
    e0++;
    wait_eop(0, e0);
    chk("t1_grant_cycles", 32'(grant_cycles), 32'd12);

    // Burst IO2M on ch1: source held at 0x200
    set_ch(1, 10'h200, 10'h170, 8'd2, BurstIO2M);
    pulse(2'b10);
    e1++;
    wait_eop(1, e1);

    // Both armed together: ch0 then ch1
    set_ch(0, 10'h010, 10'h020, 8'd2, BurstM2M);
    set_ch(1, 10'h030, 10'h220, 8'd2, BurstM2IO);
    pulse(2'b11);
    e0++; e1++;
    wait_eop(1, e1);
    chk("t3_eop0", 32'(eop_cnt[0]), 32'(e0));

    // After ch0 is served alone, a simultaneous request goes to ch1 first
    set_ch(0, 10'h012, 10'h024, 8'd1, BurstM2M);
    pulse(2'b01);
    e0++;
    wait_eop(0, e0);
    set_ch(1, 10'h032, 10'h221, 8'd1, BurstM2IO);
    set_ch(0, 10'h013, 10'h025, 8'd1, BurstM2M);
    pulse(2'b11);
    e0++; e1++;
    wait_eop(0, e0);
    chk("t3b_eop1", 32'(eop_cnt[1]), 32'(e1));

    // Single mode: pause after first word when dreq_ is released
    set_ch(0, 10'h080, 10'h090, 8'd2, SingleM2M);
    @(posedge clk); #1;
    dreq_[0] = 1'b0;
    n = 0;
    while (wq.size() > 1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    dreq_[0] = 1'b1;
    chk("single_first_word", 32'(wq.size()), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("single_paused", 32'(wq.size()), 32'd1);
    chk("single_no_eop", 32'(eop_cnt[0]), 32'(e0));
    chk("single_paused_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 dreq_[0] = 1'b0;
    @(posedge clk); #1 dreq_[0] = 1'b1;
    e0++;
    wait_eop(0, e0);

    // Source wraps from 0x3FF to 0x000
    set_ch(1, 10'h3FF, 10'h100, 8'd2, BurstM2M);
    pulse(2'b10);
    e1++;
    wait_eop(1, e1);

    // Count 0: immediate eop_, no bus request
    set_ch(0, 10'h000, 10'h000, 8'd0, BurstM2M);
    breq_cycles = 0;
    pulse(2'b01);
    @(negedge clk);
    chk("zc_eop", 32'(eop_), 32'h2);
    e0++;
    repeat (10) @(negedge clk);
    #1;
    chk("zc_breq_cycles", 32'(breq_cycles), 32'd0);
    chk("zc_eop_count", 32'(eop_cnt[0]), 32'(e0));

    // Reset in the middle of a burst abandons it without eop_
    set_ch(0, 10'h040, 10'h0C0, 8'd4, BurstM2M);
    pulse(2'b01);
    n = 0;
    while (wq.size() > 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rb_first_word", 32'(wq.size()), 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rb_breq", 32'(bus.breq_), 32'd1);
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_eop", 32'(eop_), 32'h3);
    wq.delete();
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("rb_no_eop", 32'(eop_cnt[0]), 32'(e0));
    chk("rb_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_mc.md
# dma_mc

Parametrised multi-channel DMA controller, the successor to the single-channel DMA in `top`. Each of NCH channels is armed by its own `dreq_` and carries source/destination address, word count and transfer mode. A round-robin arbiter selects a channel, the controller requests the shared memory/IO bus with `breq_`/`bgrt_`, moves words by read-then-write, and pulses the channel's `eop_` when done. It sits between the processor bus arbiter and the memory/IO address space.

## Interface
- ADDR_W, 10, bus address width
- DATA_W, 8, data width
- NCH, 2, number of channels (1..8)
- CNT_W, 8, word-count width
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `dreq_` in NCH: per-channel request, active low
- `dsaddr` in NCH*ADDR_W: source addresses, channel i at [i*ADDR_W +: ADDR_W]
- `ddaddr` in NCH*ADDR_W: destination addresses
- `dcount` in NCH*CNT_W: word counts
- `dmode` in NCH*2: modes (SingleM2M, BurstM2M, BurstIO2M, BurstM2IO)
- `eop_` out NCH: end-of-process, one-cycle low pulse
- `breq_` out 1: bus request, active low
- `bgrt_` in 1: bus grant, active low
- `addr` out ADDR_W: bus address
- `rw_` out 1: `Read`/`Write`
- `wdata` out DATA_W: write data
- `rdata` in DATA_W: read data, valid the cycle after the read address
- `busy` out 1: a transfer is in progress

## Operation
- Arming: channel idle and `dreq_[i]` low → latch dsaddr/ddaddr/dcount/dmode into channel registers; the channel becomes pending. Changes to the inputs afterwards are ignored until completion.
- Arbitration: round-robin over pending channels. Priority pointer = last served + 1. Ties resolved by the pointer only.
- FSM: IDLE → REQ (`breq_`=0) → wait for `bgrt_`=0 → RD (addr=src, rw_=Read) → RWAIT (rdata sampled at end) → WR (addr=dst, rw_=Write, wdata=sampled) → NEXT (update addr/count) → RD, DONE or REL.
- Address update: M2M increments src and dst. IO2M holds src fixed and increments dst. M2IO increments src and holds dst fixed. Arithmetic is modulo 2^ADDR_W, so 0x3FF+1 wraps to 0x000.
- Burst modes: the bus is held until count reaches 0, then DONE: `eop_[i]` low one cycle, `breq_` high, channel idle, pointer advances.
- SingleM2M: after each word, REL releases `breq_` for one cycle and the channel re-enters arbitration. Its `dreq_` is resampled; if high, the channel pauses with its progress kept.
- Count 0: no bus request; `eop_` pulses the cycle after arming.
- `bgrt_` withdrawn mid-word: the current WR completes, then the FSM goes to REQ with state kept.
- Burst `dreq_` deassertion: ignored.

## Timing
- Reset values: `breq_`=1, `rw_`=Read, `addr`=0, `wdata`=0, `eop_`=all 1, `busy`=0. All channels idle, pointer=0.
- Reset mid-transfer: at the next edge the block is in IDLE with reset outputs. The partial transfer is abandoned and no `eop_` is issued.
- Timeline: `dreq_` low at edge t → armed t+1 → `breq_` low t+2.
- `bgrt_` low sampled at edge g → RD at g+1.
- Each word takes 3 cycles (RD, RWAIT, WR) plus 1 NEXT cycle. A burst of N words occupies 4N cycles after grant, and `eop_` is low in the cycle after the final NEXT.
- Single mode adds 1 REL cycle plus re-grant latency per word.
- `busy` is high from REQ through DONE inclusive.

## Configuration
- `DMA_AUTOINIT_EN` defined: each channel keeps shadow copies of its armed addresses and count. On DONE it reloads them and becomes pending again if `dreq_[i]` is low, without waiting for rearming. `eop_` still pulses at each completion.
- Not defined: no shadow registers; the channel returns to idle after DONE.

## Structure
- Package `dma_mc_pkg`: FSM state enum, 2-bit mode encodings (SingleM2M=0, BurstM2M=1, BurstIO2M=2, BurstM2IO=3), and `Read`/`Write`/`Enable_`/`Disable_` constants.
- Sub-module `dma_rr_arb` (parameter NCH): pending vector and advance strobe in, one-hot grant and index out.
- Channel registers are a generate loop in `dma_mc`.

## Test plan
- BurstM2M, ch0, src 0x150, dst 0x160, count 3, memory 0x150..152 = 99/90/50 → 0x160..162 = 99/90/50; one `eop_[0]` pulse; `breq_` low for 12 cycles after grant.
- BurstIO2M, src 0x200 (counter value 0x0F), dst 0x170, count 2 → 0x170 and 0x171 = 0x0F; `addr` shows 0x200 on both RD cycles.
- Both channels armed in the same cycle (ch0 BurstM2M, ch1 BurstM2IO to 0x220) → ch0 served first and ch1 second; ch1 gets the next grant if ch0 is rearmed.
- SingleM2M count 2, `dreq_` raised after the first word → one word moved, channel paused; lowering `dreq_` completes word 2 and fires `eop_`.
- Src 0x3FF, count 2 → second read at 0x000. Count 0 → `eop_` pulse, `breq_` never low.
- Reset asserted mid-burst → next cycle `breq_`=1, `busy`=0, no `eop_`. With `DMA_AUTOINIT_EN` and `dreq_` held low, the channel restarts from the shadow addresses.
